// File: rtl/multiplier_issue_taint_track.sv
// Issue stage in front of a multi-cycle multiplier, with taint tracking.
// It accepts one operand pair, pulses mul_start and holds the operands until
// the multiplier reports completion. It then captures the product and the
// measured latency, and offers them downstream until they are taken.
// Data taint flows bitwise alongside each value. Taint on a control decision
// (handshake/done) is recorded in a sticky bit that taints every control output.
module multiplier_issue_taint_track #(
    parameter int WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_valid_t,
    output logic                 in_ready,
    output logic                 in_ready_t,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_a_t,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_b_t,
    output logic                 mul_start,
    output logic                 mul_start_t,
    output logic [WIDTH-1:0]     mul_multiplier,
    output logic [WIDTH-1:0]     mul_multiplier_t,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic [WIDTH-1:0]     mul_multiplicand_t,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic [2*WIDTH-1:0]   mul_product_t,
    input  logic                 mul_productDone,
    input  logic                 mul_productDone_t,
    output logic                 out_valid,
    output logic                 out_valid_t,
    input  logic                 out_ready,
    input  logic                 out_ready_t,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [2*WIDTH-1:0]   out_product_t,
    output logic [15:0]          lat_cycles,
    output logic [15:0]          lat_cycles_t
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     a_reg, b_reg, a_t_reg, b_t_reg;
    logic [WIDTH-1:0]     a_t_next, b_t_next;
    logic [2*WIDTH-1:0]   prod_reg, prod_t_reg;
    logic [15:0]          lat_reg, lat_t_reg;
    logic [15:0]          cnt_reg, cnt_inc;
    logic                 st_t_reg, st_t_next;
    logic                 accept, done_take, out_take;

    // A valid that is itself tainted taints every captured operand bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_op_taint
            assign a_t_next[gi] = in_a_t[gi] | in_valid_t;
            assign b_t_next[gi] = in_b_t[gi] | in_valid_t;
        end
    endgenerate

    // Latency counter step, saturating so a hung multiplier cannot wrap it.
    assign cnt_inc = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

    // Next state, handshake events and sticky control-taint update.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        done_take  = 1'b0;
        out_take   = 1'b0;
        st_t_next  = st_t_reg;
        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                    st_t_next  = st_t_reg | in_valid_t;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (mul_productDone) begin
                    done_take  = 1'b1;
                    state_next = HOLD;
                    st_t_next  = st_t_reg | mul_productDone_t;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_take   = 1'b1;
                    state_next = IDLE;
                    st_t_next  = st_t_reg | out_ready_t;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons whatever operation is in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            st_t_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            st_t_reg  <= st_t_next;
        end
    end

    // Operand, latency-counter and result capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            a_t_reg    <= '0;
            b_t_reg    <= '0;
            prod_reg   <= '0;
            prod_t_reg <= '0;
            lat_reg    <= '0;
            lat_t_reg  <= '0;
            cnt_reg    <= '0;
        end else begin
            if (accept) begin
                a_reg   <= in_a;
                b_reg   <= in_b;
                a_t_reg <= a_t_next;
                b_t_reg <= b_t_next;
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= 16'd0;
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_inc;
            end
            if (done_take) begin
                prod_reg   <= mul_product;
                prod_t_reg <= mul_product_t | {(2*WIDTH){mul_productDone_t}};
                lat_reg    <= cnt_inc;
                lat_t_reg  <= {16{st_t_next}};
            end
        end
    end

    assign in_ready           = (state_reg == IDLE);
    assign mul_start          = (state_reg == ISSUE);
    assign out_valid          = (state_reg == HOLD);
    assign in_ready_t         = st_t_reg;
    assign mul_start_t        = st_t_reg;
    assign out_valid_t        = st_t_reg;
    assign mul_multiplier     = a_reg;
    assign mul_multiplicand   = b_reg;
    assign mul_multiplier_t   = a_t_reg;
    assign mul_multiplicand_t = b_t_reg;
    assign out_product        = prod_reg;
    assign out_product_t      = prod_t_reg;
    assign lat_cycles         = lat_reg;
    assign lat_cycles_t       = lat_t_reg;

endmodule

// File: doc/multiplier_issue_taint_track.md
MULTIPLIER_ISSUE_TAINT_TRACK -- requirements
Module: multiplier_issue_taint_track

Interface
REQ-001 SHALL have parameter WIDTH, default 128, giving the operand width of the downstream multiplier; the product is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have ports in_valid/in_valid_t, input, 1: operand-pair offer and its taint.
REQ-005 SHALL have ports in_ready/in_ready_t, output, 1: operand accept and its taint.
REQ-006 SHALL have ports in_a/in_a_t, input, WIDTH: multiplier operand and its bitwise taint.
REQ-007 SHALL have ports in_b/in_b_t, input, WIDTH: multiplicand operand and its bitwise taint.
REQ-008 SHALL have ports mul_start/mul_start_t, output, 1: start pulse to the multiplier and its taint.
REQ-009 SHALL have ports mul_multiplier/mul_multiplier_t and mul_multiplicand/mul_multiplicand_t, output, WIDTH: held operands and their taint.
REQ-010 SHALL have ports mul_product/mul_product_t, input, 2*WIDTH: multiplier product and its taint.
REQ-011 SHALL have ports mul_productDone/mul_productDone_t, input, 1: multiplier completion and its taint.
REQ-012 SHALL have ports out_valid/out_valid_t, output, 1: result available and its taint.
REQ-013 SHALL have ports out_ready/out_ready_t, input, 1: result consumer accept and its taint.
REQ-014 SHALL have ports out_product/out_product_t, output, 2*WIDTH: captured product and its taint.
REQ-015 SHALL have ports lat_cycles/lat_cycles_t, output, 16: measured multiply latency and its taint.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT and HOLD.
REQ-017 SHALL drive in_ready=1 only in IDLE; in_valid&in_ready SHALL capture in_a/in_b into the operand registers, with taint in_x_t | {WIDTH{in_valid_t}}, and move to ISSUE.
REQ-018 SHALL drive mul_start=1 for exactly the one ISSUE cycle, clear the latency counter to 0, and move to WAIT.
REQ-019 SHALL drive mul_multiplier/mul_multiplicand and their taints from the operand registers continuously, stable from capture until the next accept.
REQ-020 SHALL increment the counter by 1 in each WAIT cycle, including the cycle in which mul_productDone=1, saturating at 0xFFFF.
REQ-021 SHALL have no timeout: WAIT holds indefinitely until mul_productDone=1.
REQ-022 SHALL, in WAIT with mul_productDone=1, load out_product <= mul_product, out_product_t <= mul_product_t | {2*WIDTH{mul_productDone_t}}, lat_cycles <= the incremented counter, and move to HOLD.
REQ-023 SHALL ignore mul_productDone and mul_product outside WAIT.
REQ-024 SHALL drive out_valid=1 only in HOLD; out_valid&out_ready SHALL return to IDLE, and out_product/lat_cycles SHALL hold until the next capture.
REQ-025 SHALL never assert in_ready and out_valid together; back-to-back throughput is 1 operation per (latency+3) cycles minimum.
REQ-026 SHALL keep a sticky control-taint bit st_t, set when a transition is taken while its deciding input is tainted: in_valid_t in IDLE, mul_productDone_t in WAIT, or out_ready_t in HOLD.
REQ-027 SHALL clear st_t only on reset.
REQ-028 SHALL drive in_ready_t, mul_start_t and out_valid_t equal to st_t.
REQ-029 SHALL set lat_cycles_t to {16{st_t}} as updated at capture.

Reset
REQ-030 SHALL, on rst=0 at a clock edge, enter IDLE and clear all registers to 0: operands, product, lat_cycles, all taints and st_t.
REQ-031 SHALL drive outputs as follows the cycle after a reset edge: in_ready=1, mul_start=0, out_valid=0, all data and taint outputs=0.
REQ-032 SHALL abandon any in-flight operation on reset mid-operation in any state, with no start pulse and no result emitted; a late mul_productDone SHALL be ignored per REQ-023.

Verification
REQ-033 SHALL cover, at WIDTH=8: accept a=3, b=5, untainted; multiplier model returns done 9 cycles after start with product 15 -> one mul_start pulse; out_product=15; lat_cycles=9; all taints 0.
REQ-034 SHALL cover: in_a_t=0x01, other taints 0 -> mul_multiplier_t=0x01; st_t stays 0; out_product_t equals model product_t.
REQ-035 SHALL cover: in_valid_t=1 on accept -> mul_multiplier_t=mul_multiplicand_t=0xFF; in_ready_t/mul_start_t/out_valid_t=1 thereafter until reset.
REQ-036 SHALL cover: mul_productDone_t=1 at done -> out_product_t=0xFFFF; lat_cycles_t=0xFFFF.
REQ-037 SHALL cover: out_ready held 0 for 5 cycles in HOLD -> out_valid stays 1; in_ready stays 0; data stable.
REQ-038 SHALL cover: rst=0 during WAIT, then stray mul_productDone=1 -> IDLE; out_valid never asserted; all outputs per REQ-031.
